// File: rtl/xbar_pkg.sv
// Shared constants and helpers for the crossbar scheduler and its arbiters.
package xbar_pkg;

    localparam int         NUM_PORTS = 3;
    localparam logic [1:0] SEL_IDLE  = 2'd3;

    // Low bit of the 2-bit select field that drives output o.
    function automatic int unsigned sel_field(input int unsigned o);
        return 2 * o;
    endfunction

    // (p + k) mod 3 for p, k in 0..3; the result never takes the value 3.
    function automatic logic [1:0] wrap3(input logic [1:0] p, input logic [1:0] k);
        logic [2:0] s;
        s = {1'b0, p} + {1'b0, k};
        if (s >= 3'd3) s = s - 3'd3;
        if (s >= 3'd3) s = s - 3'd3;
        return s[1:0];
    endfunction

endpackage

// File: rtl/rr_arb3.sv
// Three-request round-robin arbiter; the pointer marks the highest-priority request.
module rr_arb3
    import xbar_pkg::*;
(
    input  logic [2:0] req_i,
    input  logic [1:0] ptr_i,
    output logic [1:0] gnt_idx_o,
    output logic       gnt_vld_o
);

    logic [1:0] c0, c1, c2;

    assign c0 = wrap3(ptr_i, 2'd0);
    assign c1 = wrap3(ptr_i, 2'd1);
    assign c2 = wrap3(ptr_i, 2'd2);

    // Scan lowest priority first so the pointer's own candidate overwrites last.
    always_comb begin
        gnt_idx_o = SEL_IDLE;
        gnt_vld_o = 1'b0;
        if (req_i[c2]) begin
            gnt_idx_o = c2;
            gnt_vld_o = 1'b1;
        end
        if (req_i[c1]) begin
            gnt_idx_o = c1;
            gnt_vld_o = 1'b1;
        end
        if (req_i[c0]) begin
            gnt_idx_o = c0;
            gnt_vld_o = 1'b1;
        end
    end

endmodule

// File: rtl/xbar_sched.sv
// Registered 3x3 crossbar scheduler: per-output round-robin arbitration feeding a
// single pipeline register, with global backpressure and a saturating drop counter.
module xbar_sched
    import xbar_pkg::*;
#(
    parameter int DW    = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       in_valid,
    input  logic [DW-1:0]    in_data0,
    input  logic [DW-1:0]    in_data1,
    input  logic [DW-1:0]    in_data2,
    input  logic [1:0]       in_dest0,
    input  logic [1:0]       in_dest1,
    input  logic [1:0]       in_dest2,
    output logic [2:0]       in_ready,
    input  logic             out_ready,
    output logic [DW-1:0]    xb_in0,
    output logic [DW-1:0]    xb_in1,
    output logic [DW-1:0]    xb_in2,
    output logic [5:0]       xb_select,
    output logic [2:0]       xb_valid,
    output logic [CNT_W-1:0] drop_cnt
);

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [1:0]       b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    logic [1:0]    dest     [NUM_PORTS];
    logic [DW-1:0] data     [NUM_PORTS];
    logic [2:0]    req      [NUM_PORTS];
    logic [1:0]    gnt_idx  [NUM_PORTS];
    logic [2:0]    gnt_vld;
    logic [2:0]    won;
    logic [2:0]    dest_bad;
    logic [1:0]    n_drop;
    logic          adv;

    logic [1:0]       rr_q     [NUM_PORTS];
    logic [1:0]       rr_d     [NUM_PORTS];
    logic [DW-1:0]    xb_in_q  [NUM_PORTS];
    logic [DW-1:0]    xb_in_d  [NUM_PORTS];
    logic [5:0]       sel_q, sel_d;
    logic [2:0]       vld_q, vld_d;
    logic [CNT_W-1:0] drop_q, drop_d;

    assign dest[0] = in_dest0;
    assign dest[1] = in_dest1;
    assign dest[2] = in_dest2;
    assign data[0] = in_data0;
    assign data[1] = in_data1;
    assign data[2] = in_data2;

    assign adv = out_ready & ~rst;

    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            req[o] = '0;
            for (int i = 0; i < NUM_PORTS; i++)
                req[o][i] = in_valid[i] & (dest[i] == 2'(o));
        end
    end

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_arb
        rr_arb3 u_arb (
            .req_i     (req[o]),
            .ptr_i     (rr_q[o]),
            .gnt_idx_o (gnt_idx[o]),
            .gnt_vld_o (gnt_vld[o])
        );
    end

    // A source names a single output, so it can be the winner of at most one arbiter.
    always_comb begin
        won      = '0;
        dest_bad = '0;
        for (int o = 0; o < NUM_PORTS; o++)
            if (gnt_vld[o]) won[gnt_idx[o]] = 1'b1;
        for (int i = 0; i < NUM_PORTS; i++)
            dest_bad[i] = (dest[i] == SEL_IDLE);
    end

    assign in_ready = adv ? (won | dest_bad) : 3'b000;
    assign n_drop   = {1'b0, in_valid[0] & dest_bad[0]}
                    + {1'b0, in_valid[1] & dest_bad[1]}
                    + {1'b0, in_valid[2] & dest_bad[2]};

    always_comb begin
        sel_d  = '0;
        vld_d  = gnt_vld;
        drop_d = sat_add(drop_q, n_drop);
        for (int i = 0; i < NUM_PORTS; i++) begin
            xb_in_d[i] = won[i] ? data[i] : '0;
            rr_d[i]    = gnt_vld[i] ? wrap3(gnt_idx[i], 2'd1) : rr_q[i];
            sel_d[sel_field(i) +: 2] = gnt_vld[i] ? gnt_idx[i] : SEL_IDLE;
        end
    end

    // Pipeline register: loads only when the consumer advances.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q  <= 6'h3F;
            vld_q  <= '0;
            drop_q <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                xb_in_q[i] <= '0;
                rr_q[i]    <= '0;
            end
        end else if (adv) begin
            sel_q  <= sel_d;
            vld_q  <= vld_d;
            drop_q <= drop_d;
            for (int i = 0; i < NUM_PORTS; i++) begin
                xb_in_q[i] <= xb_in_d[i];
                rr_q[i]    <= rr_d[i];
            end
        end
    end

    assign xb_in0    = xb_in_q[0];
    assign xb_in1    = xb_in_q[1];
    assign xb_in2    = xb_in_q[2];
    assign xb_select = sel_q;
    assign xb_valid  = vld_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_xbar_sched.sv
// Bench for xbar_sched: directed scenarios plus constrained-random traffic, all
// checked cycle by cycle against a behavioural scheduler model.
module tb_xbar_sched;

    localparam int DW    = 8;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       in_valid;
    logic [DW-1:0]    in_data0, in_data1, in_data2;
    logic [1:0]       in_dest0, in_dest1, in_dest2;
    logic [2:0]       in_ready;
    logic             out_ready;
    logic [DW-1:0]    xb_in0, xb_in1, xb_in2;
    logic [5:0]       xb_select;
    logic [2:0]       xb_valid;
    logic [CNT_W-1:0] drop_cnt;

    xbar_sched #(.DW(DW), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data0  (in_data0),
        .in_data1  (in_data1),
        .in_data2  (in_data2),
        .in_dest0  (in_dest0),
        .in_dest1  (in_dest1),
        .in_dest2  (in_dest2),
        .in_ready  (in_ready),
        .out_ready (out_ready),
        .xb_in0    (xb_in0),
        .xb_in1    (xb_in1),
        .xb_in2    (xb_in2),
        .xb_select (xb_select),
        .xb_valid  (xb_valid),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Model state: pointers, expected register contents, last-cycle acceptance.
    int m_rr  [3];
    int m_in  [3];
    int m_sel [3];
    int m_vld [3];
    int m_drop;
    bit m_acc [3];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic set_src(input int i, input bit v, input logic [7:0] d, input logic [1:0] ds);
        in_valid[i] = v;
        case (i)
            0: begin in_data0 = d; in_dest0 = ds; end
            1: begin in_data1 = d; in_dest1 = ds; end
            default: begin in_data2 = d; in_dest2 = ds; end
        endcase
    endtask

    // Called at posedge+1: checks in_ready mid-cycle, then registered outputs after the edge.
    task automatic cycle(input string tag);
        int v[3], d[3], ds[3], win[3];
        int ndrop, s, exp_rdy, exp_sel, exp_vld;
        bit adv;
        #3;
        v[0] = in_valid[0]; v[1] = in_valid[1]; v[2] = in_valid[2];
        d[0] = in_data0;    d[1] = in_data1;    d[2] = in_data2;
        ds[0] = in_dest0;   ds[1] = in_dest1;   ds[2] = in_dest2;
        adv = out_ready && !rst;
        for (int o = 0; o < 3; o++) begin
            win[o] = -1;
            for (int k = 0; k < 3; k++) begin
                s = (m_rr[o] + k) % 3;
                if (win[o] < 0 && v[s] != 0 && ds[s] == o) win[o] = s;
            end
        end
        exp_rdy = 0;
        for (int i = 0; i < 3; i++) begin
            m_acc[i] = adv && (ds[i] == 3 || win[ds[i]] == i);
            if (m_acc[i]) exp_rdy += (1 << i);
        end
        chk({tag, "_rdy"}, {29'd0, in_ready}, exp_rdy);
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                m_rr[i] = 0; m_in[i] = 0; m_sel[i] = 3; m_vld[i] = 0;
            end
            m_drop = 0;
        end else if (adv) begin
            ndrop = 0;
            for (int i = 0; i < 3; i++) begin
                if (v[i] != 0 && ds[i] == 3) ndrop++;
                m_in[i] = (ds[i] < 3 && win[ds[i]] == i) ? d[i] : 0;
            end
            m_drop = (m_drop + ndrop > 255) ? 255 : m_drop + ndrop;
            for (int o = 0; o < 3; o++) begin
                m_sel[o] = (win[o] < 0) ? 3 : win[o];
                m_vld[o] = (win[o] < 0) ? 0 : 1;
                if (win[o] >= 0) m_rr[o] = (win[o] + 1) % 3;
            end
        end
        #1;
        exp_sel = m_sel[0] + 4 * m_sel[1] + 16 * m_sel[2];
        exp_vld = m_vld[0] + 2 * m_vld[1] + 4 * m_vld[2];
        chk({tag, "_in0"}, {24'd0, xb_in0}, m_in[0]);
        chk({tag, "_in1"}, {24'd0, xb_in1}, m_in[1]);
        chk({tag, "_in2"}, {24'd0, xb_in2}, m_in[2]);
        chk({tag, "_sel"}, {26'd0, xb_select}, exp_sel);
        chk({tag, "_vld"}, {29'd0, xb_valid}, exp_vld);
        chk({tag, "_drop"}, {24'd0, drop_cnt}, m_drop);
    endtask

    initial begin
        rst = 1'b1; out_ready = 1'b0; in_valid = '0;
        in_data0 = '0; in_data1 = '0; in_data2 = '0;
        in_dest0 = '0; in_dest1 = '0; in_dest2 = '0;
        for (int i = 0; i < 3; i++) begin
            m_rr[i] = 0; m_in[i] = 0; m_sel[i] = 3; m_vld[i] = 0; m_acc[i] = 0;
        end
        m_drop = 0;
        @(posedge clk); #1;
        cycle("rst"); cycle("rst");
        chk("rst_sel", {26'd0, xb_select}, 32'h3F);
        chk("rst_vld", {29'd0, xb_valid}, 32'd0);

        // Distinct destinations: all granted together.
        rst = 1'b0; out_ready = 1'b1;
        set_src(0, 1, 8'h11, 2'd0); set_src(1, 1, 8'h22, 2'd1); set_src(2, 1, 8'h33, 2'd2);
        cycle("t1");
        chk("t1_sel_lit", {26'd0, xb_select}, 32'b10_01_00);
        chk("t1_in2_lit", {24'd0, xb_in2}, 32'h33);

        rst = 1'b1; cycle("t2rst"); rst = 1'b0;

        // Three sources contending for output 1 rotate 0,1,2.
        set_src(0, 1, 8'h01, 2'd1); set_src(1, 1, 8'h02, 2'd1); set_src(2, 1, 8'h03, 2'd1);
        for (int k = 0; k < 3; k++) begin
            cycle("t2");
            chk("t2_sel1_lit", {30'd0, xb_select[3:2]}, k);
            chk("t2_vld_lit", {29'd0, xb_valid}, 32'b010);
        end

        // Illegal destination: always accepted, drop counter saturates.
        in_valid = 3'b000;
        set_src(2, 1, 8'hA5, 2'd3);
        for (int k = 0; k < 300; k++) cycle("t3");
        chk("t3_drop_lit", {24'd0, drop_cnt}, 32'hFF);

        // Backpressure holds everything, then grants complete on release.
        out_ready = 1'b0;
        set_src(0, 1, 8'h44, 2'd1); set_src(1, 1, 8'h55, 2'd1); set_src(2, 1, 8'h66, 2'd0);
        for (int k = 0; k < 4; k++) cycle("t4");
        out_ready = 1'b1;
        cycle("t4go");

        // Reset mid-stream restores pointers and clears the drop counter.
        rst = 1'b1; cycle("t5a"); rst = 1'b0;
        set_src(0, 1, 8'h77, 2'd1); set_src(1, 1, 8'h88, 2'd1); set_src(2, 1, 8'h99, 2'd3);
        cycle("t5b");
        rst = 1'b1;
        cycle("t5rst");
        chk("t5_sel_lit", {26'd0, xb_select}, 32'h3F);
        chk("t5_drop_lit", {24'd0, drop_cnt}, 32'd0);
        rst = 1'b0;
        cycle("t5c");
        chk("t5_first_lit", {30'd0, xb_select[3:2]}, 32'd0);

        // Random traffic; stalled requests are held until accepted.
        for (int n = 0; n < 800; n++) begin
            for (int i = 0; i < 3; i++)
                if (!in_valid[i] || m_acc[i])
                    set_src(i, $urandom_range(0, 3) != 0, 8'($urandom), 2'($urandom_range(0, 3)));
            out_ready = $urandom_range(0, 3) != 0;
            rst = $urandom_range(0, 63) == 0;
            cycle("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/xbar_sched.md
Name: xbar_sched

Overview:
Registered scheduler stage directly upstream of the 3x3 byte crossbar.
- Accepts one request per source port per cycle: data byte plus destination output index.
- Resolves contention per output with round-robin priority.
- Drives the crossbar's in0/in1/in2 and 6-bit select from a single pipeline register, with per-output valid flags.
- Backpressure uses a single global ready from the consumer.

Parameters:
DW, 8, data width of each source/crossbar byte lane
CNT_W, 8, width of the saturating drop counter

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  3  per-source request valid, bit i = source i
in_data0  input  DW  source 0 data
in_data1  input  DW  source 1 data
in_data2  input  DW  source 2 data
in_dest0  input  2  source 0 destination output (0..2 legal, 3 illegal)
in_dest1  input  2  source 1 destination output
in_dest2  input  2  source 2 destination output
in_ready  output  3  per-source accept; handshake completes when in_valid[i] & in_ready[i]
out_ready  input  1  downstream can take the current register contents
xb_in0  output  DW  registered crossbar input 0
xb_in1  output  DW  registered crossbar input 1
xb_in2  output  DW  registered crossbar input 2
xb_select  output  6  registered crossbar select; [1:0]=out0 source, [3:2]=out1, [5:4]=out2; 2'd3 = output idle
xb_valid  output  3  registered per-output valid, bit o = output o carries a transfer
drop_cnt  output  CNT_W  saturating count of accepted requests with illegal dest

Behaviour:
- Interface: one clock, clk. rst is synchronous and active-high. There is no asynchronous reset path.
- Reset values:
  - xb_in0..2 = 0; xb_select = 6'h3F (all idle); xb_valid = 3'b000.
  - drop_cnt = 0; round-robin pointers rr0..rr2 = 0.
  - rst overrides out_ready and any in-flight handshake. A request pending during rst is not accepted, and in_ready = 0 while rst = 1.
- Advance condition: adv = out_ready & ~rst. When adv = 0 the register and pointers hold, and in_ready = 3'b000.
- Arbitration (combinational, per output o):
  - Candidates are sources i with in_valid[i] & in_dest_i == o.
  - The winner is the first candidate scanning i = rr_o, rr_o+1, rr_o+2 (mod 3).
  - Each source names one dest, so a source wins at most one output. There are no cross-output conflicts.
- Grants:
  - in_ready[i] = adv & (i won its dest, or in_dest_i == 3).
  - A losing source sees in_ready[i] = 0 and must hold its data and dest stable; the stall is retried next cycle.
- Pointer update on adv: if output o granted source g, then rr_o <= (g+1) mod 3. Otherwise rr_o holds. The pointer never takes the value 3.
- Register load on adv:
  - xb_inN <= in_dataN if source N was granted a legal output, else 0.
  - xb_select field o <= winner index, or 2'd3 if no candidate.
  - xb_valid[o] <= 1 iff a winner exists.
- Latency: exactly one cycle from handshake to the xb_* outputs.
- Illegal dest (3):
  - The request is accepted when adv = 1 and the data is discarded.
  - drop_cnt increments by the number of illegal requests accepted that cycle (0..3) and saturates at 2^CNT_W-1.
- Simultaneous events: all three sources may target distinct outputs and all are granted in one cycle. Two or three sources on one output are resolved by round-robin, with the rest stalled.
- Fairness: with continuous contention on one output, each contending source is granted at least once every 3 adv cycles.

Decomposition:
- Shared package xbar_pkg:
  - constants NUM_PORTS = 3 and SEL_IDLE = 2'd3;
  - function sel_field(o) returning the bit range of select for output o.
- Sub-module rr_arb3: 3-request round-robin arbiter with a 2-bit pointer, req[2:0] in, grant index plus grant_valid out. It is instantiated once per output; pointer state stays in xbar_sched.
- Everything else (pipeline register, drop counter, ready logic) lives in the top.

Test Plan:
1. Reset, then out_ready=1, in_valid=3'b111, dests 0/1/2, data 11/22/33.
   -> in_ready=3'b111; next cycle xb_select=6'b10_01_00, xb_valid=3'b111, xb_in0..2 = 11/22/33.
2. All sources dest 1, held valid for 3 cycles with rr1=0.
   -> grants source 0, then 1, then 2; xb_select[3:2] = 0,1,2; xb_select[1:0] and [5:4] = 3; xb_valid = 3'b010 each cycle.
3. Source 2 dest 3, data A5, repeated 300 cycles with out_ready=1.
   -> in_ready[2]=1 every cycle; xb_valid=0; drop_cnt saturates at FF.
4. out_ready=0 for 4 cycles with valid requests pending.
   -> in_ready=0; xb_* and rr pointers unchanged. out_ready=1 then completes the grants one cycle later.
5. rst asserted mid-stream after scenario 2 cycle 1.
   -> next edge: xb_select=6'h3F, xb_valid=0, drop_cnt=0, rr1=0; the first post-reset grant on output 1 goes to source 0.
